// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB arbiter.
// Combinational decode only; no timing or flow control of its own.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam int unsigned WAIT_CNT_W         = 16;

endpackage

// File: rtl/apb_arb_rr.sv
// Two-way round-robin pick: one-hot grant from two requests and the last-served index.
// Zero latency (combinational); a lone request always wins, a tie goes to the other side.
module apb_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB completer port between two requesters; SETUP/ACCESS add one cycle of
// arbitration, losers are stalled by a held-low pready, a silent slave is cut off by timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [31:0]       m0_pwdata,
    output logic [31:0]       m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,

    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [31:0]       m1_pwdata,
    output logic [31:0]       m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,

    output logic              out_psel,
    output logic              out_penable,
    output logic              out_pwrite,
    output logic [ADDR_W-1:0] out_paddr,
    output logic [31:0]       out_pwdata,
    input  logic [31:0]       out_prdata,
    input  logic              out_pready,
    input  logic              out_pslverr,

    output logic              timeout_err
);

    localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e            state_q;
    logic [1:0]            gnt_q;
    logic                  last_q;
    logic [WAIT_CNT_W-1:0] cnt_q;

    logic [1:0]            rr_gnt;
    logic                  bus_busy;
    logic                  bus_access;
    logic                  tmo_hit;
    logic                  xfer_done;
    logic [1:0]            rsp_sel;

    // Arbitration keys off psel alone; the requesters' own penable carries no extra information.
    logic                  unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    apb_arb_rr u_rr (
        .req_i  ({m1_psel, m0_psel}),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_psel || m1_psel) begin
                        gnt_q   <= rr_gnt;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q   <= '0;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        last_q  <= gnt_q[1];
                        gnt_q   <= 2'b00;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    gnt_q   <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reset masks the bus immediately so an aborted transfer never leaks a response.
    assign bus_busy   = !preset && ((state_q == SETUP) || (state_q == ACCESS));
    assign bus_access = !preset && (state_q == ACCESS);
    assign tmo_hit    = bus_access && !out_pready && (cnt_q == TMO_LAST);
    assign xfer_done  = out_pready || tmo_hit;
    assign rsp_sel    = bus_access ? gnt_q : 2'b00;

    assign out_psel    = bus_busy;
    assign out_penable = bus_access;
    assign out_paddr   = !bus_busy ? '0    : (gnt_q[1] ? m1_paddr  : m0_paddr);
    assign out_pwrite  = !bus_busy ? 1'b0  : (gnt_q[1] ? m1_pwrite : m0_pwrite);
    assign out_pwdata  = !bus_busy ? 32'h0 : (gnt_q[1] ? m1_pwdata : m0_pwdata);

    assign m0_pready  = rsp_sel[0] && xfer_done;
    assign m0_pslverr = rsp_sel[0] && (tmo_hit || out_pslverr);
    assign m0_prdata  = (rsp_sel[0] && !tmo_hit) ? out_prdata : 32'h0;

    assign m1_pready  = rsp_sel[1] && xfer_done;
    assign m1_pslverr = rsp_sel[1] && (tmo_hit || out_pslverr);
    assign m1_prdata  = (rsp_sel[1] && !tmo_hit) ? out_prdata : 32'h0;

    assign timeout_err = tmo_hit;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomised rounds of one or two requests against a transaction-level arbitration model;
// a negedge monitor pops expected completions from a queue and checks bus and responses.
module tb_apb_master_arbiter;

    localparam int T = 8;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          w;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        logic        tmo;
        int          acc;
        int          done_cyc;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic [31:0] m0_paddr, m0_pwdata, m0_prdata;
    logic        m0_pready, m0_pslverr;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m1_paddr, m1_pwdata, m1_prdata;
    logic        m1_pready, m1_pslverr;
    logic        out_psel, out_penable, out_pwrite;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_pready, out_pslverr;
    logic        timeout_err;

    txn_t t[2];
    exp_t q[$];
    exp_t got;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   lastg = 1;
    int   acc_n = 0;
    int   acc_cnt = 0;
    logic mon_en = 1'b0;
    logic prev_done = 1'b0;
    logic done0, done1;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_master_arbiter #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .pclk(pclk), .preset(preset),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
        .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
        .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
        .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_prdata(out_prdata),
        .out_pready(out_pready), .out_pslverr(out_pslverr),
        .timeout_err(timeout_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h need %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Expected completion of requester id whose request is first seen by an idle arbiter in cycle start.
    function automatic int push_exp(input int id, input int start);
        exp_t e;
        logic tmo;
        tmo        = (t[id].w >= T);
        e.id       = id;
        e.addr     = t[id].addr;
        e.wr       = t[id].wr;
        e.wdata    = t[id].wdata;
        e.tmo      = tmo;
        e.acc      = tmo ? T : t[id].w + 1;
        e.prdata   = tmo ? 32'h0 : t[id].rdata;
        e.slverr   = tmo | t[id].err;
        e.done_cyc = start + 1 + e.acc;
        q.push_back(e);
        return e.done_cyc;
    endfunction

    function automatic void set_txn(input int id, input logic [31:0] addr, input logic wr,
                                    input logic [31:0] wdata, input int w,
                                    input logic [31:0] rdata, input logic err);
        t[id].id    = id;
        t[id].addr  = addr;
        t[id].wr    = wr;
        t[id].wdata = wdata;
        t[id].w     = w;
        t[id].rdata = rdata;
        t[id].err   = err;
    endfunction

    function automatic void rand_txn(input int id);
        logic [31:0] base;
        base = (id == 1) ? 32'h5000_0000 : 32'h4000_0000;
        set_txn(id, base | ($urandom & 32'h0FFF_FFFC), 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 10), $urandom, ($urandom_range(0, 3) == 0));
    endfunction

    // Completer model: wait states and data come from the transaction owning the address region.
    task automatic slave_drive();
        int id;
        if (out_psel && out_penable) begin
            id          = int'(out_paddr[28]);
            out_pready  = (acc_n == t[id].w);
            out_prdata  = t[id].rdata;
            out_pslverr = t[id].err;
            acc_n++;
        end else begin
            acc_n       = 0;
            out_pready  = 1'b0;
            out_prdata  = $urandom;
            out_pslverr = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        done0 = m0_pready;
        done1 = m1_pready;
        @(posedge pclk);
        #1;
        if (done0) begin m0_psel = 1'b0; m0_penable = 1'b0; end
        else if (m0_psel) m0_penable = 1'b1;
        if (done1) begin m1_psel = 1'b0; m1_penable = 1'b0; end
        else if (m1_psel) m1_penable = 1'b1;
        #1 slave_drive();
    endtask

    task automatic run_round(input logic r0, input logic r1, input logic wd);
        int   first, d, n;
        logic served0, served1;
        first = (r0 && r1) ? ((lastg == 1) ? 0 : 1) : (r1 ? 1 : 0);
        @(posedge pclk);
        #1;
        if (r0 && r1) begin
            d = push_exp(first, cyc);
            void'(push_exp(1 - first, d + 1));
            lastg = 1 - first;
        end else begin
            void'(push_exp(first, cyc));
            lastg = first;
        end
        if (r0) begin
            m0_psel = 1'b1; m0_penable = 1'b0;
            m0_paddr = t[0].addr; m0_pwrite = t[0].wr; m0_pwdata = t[0].wdata;
        end
        if (r1) begin
            m1_psel = 1'b1; m1_penable = 1'b0;
            m1_paddr = t[1].addr; m1_pwrite = t[1].wr; m1_pwdata = t[1].wdata;
        end
        #1 slave_drive();
        served0 = !r0;
        served1 = !r1;
        n = 0;
        while (!(served0 && served1) && n < 200) begin
            tick();
            n++;
            if (done0) served0 = 1'b1;
            if (done1) served1 = 1'b1;
            if (wd && n == 1) begin
                m0_psel = 1'b0; m0_penable = 1'b0;
                m1_psel = 1'b0; m1_penable = 1'b0;
            end
        end
        chk("round_complete", {served0, served1}, 2'b11);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {out_psel, out_penable, out_pwrite, timeout_err}, 0);
        chk({tag, "_paddr"}, out_paddr, 0);
        chk({tag, "_pwdata"}, out_pwdata, 0);
        chk({tag, "_rsp"}, {m0_pready, m0_pslverr, m1_pready, m1_pslverr}, 0);
        chk({tag, "_prdata"}, m0_prdata | m1_prdata, 0);
    endtask

    always @(negedge pclk) begin
        if (!mon_en) begin
            acc_cnt   = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("idle_after_done", {out_psel, m0_pready, m1_pready}, 0);
            prev_done = 1'b0;
            if (!out_penable) begin
                chk("rsp_outside_access", {m0_pready, m0_pslverr, m1_pready, m1_pslverr}, 0);
                chk("prdata_outside_access", m0_prdata | m1_prdata, 0);
            end else if (q.size() == 0) begin
                chk("unexpected_access", out_penable, 0);
            end else begin
                acc_cnt++;
                chk("bus_addr", out_paddr, q[0].addr);
                chk("bus_wdata", out_pwdata, q[0].wdata);
                chk("bus_write", out_pwrite, q[0].wr);
                if (q[0].id == 1) chk("m0_quiet", {m0_pready, m0_pslverr, m0_prdata}, 0);
                else              chk("m1_quiet", {m1_pready, m1_pslverr, m1_prdata}, 0);
            end
            if (m0_pready || m1_pready || timeout_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {m0_pready, m1_pready, timeout_err}, 0);
                end else begin
                    got = q.pop_front();
                    chk("done_id", {m0_pready, m1_pready}, (got.id == 1) ? 2'b01 : 2'b10);
                    chk("prdata", (got.id == 1) ? m1_prdata : m0_prdata, got.prdata);
                    chk("pslverr", (got.id == 1) ? m1_pslverr : m0_pslverr, got.slverr);
                    chk("timeout_err", timeout_err, got.tmo);
                    chk("access_cycles", acc_cnt, got.acc);
                    chk("done_cycle", cyc, got.done_cyc);
                    acc_cnt   = 0;
                    prev_done = 1'b1;
                end
            end
        end
    end

    initial begin
        int   n, k;
        logic r0, r1, wd;
        preset = 1'b1;
        m0_psel = 1'b0; m0_penable = 1'b0; m0_pwrite = 1'b1;
        m1_psel = 1'b0; m1_penable = 1'b0; m1_pwrite = 1'b1;
        m0_paddr = 32'h4000_0ABC; m0_pwdata = 32'hA5A5_A5A5;
        m1_paddr = 32'h5000_0DEF; m1_pwdata = 32'h5A5A_5A5A;
        out_pready = 1'b0; out_prdata = 32'hFFFF_FFFF; out_pslverr = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk) chk_quiet("reset");
        @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk) chk_quiet("post_reset");
        mon_en = 1'b1;

        rand_txn(0); rand_txn(1);
        run_round(1'b1, 1'b1, 1'b0);
        set_txn(0, 32'h4000_0010, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        run_round(1'b1, 1'b0, 1'b0);
        rand_txn(0); rand_txn(1);
        run_round(1'b1, 1'b1, 1'b0);
        set_txn(1, 32'h5000_0004, 1'b1, 32'h1234_5678, 4, 32'h0BAD_F00D, 1'b0);
        run_round(1'b0, 1'b1, 1'b0);
        set_txn(0, 32'h4000_0020, 1'b0, 32'h0, 100, 32'hCAFE_F00D, 1'b0);
        run_round(1'b1, 1'b0, 1'b0);
        // Completer answers exactly on the last allowed cycle: a normal completion, not a timeout.
        set_txn(0, 32'h4000_0030, 1'b0, 32'h0, T - 1, 32'h600D_DA7A, 1'b0);
        run_round(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 3);
            r0 = (k != 1);
            r1 = (k != 0);
            wd = (k < 2) && ($urandom_range(0, 3) == 0);
            rand_txn(0); rand_txn(1);
            run_round(r0, r1, wd);
        end

        mon_en = 1'b0;
        set_txn(0, 32'h4000_0100, 1'b1, 32'h7777_0000, 100, 32'h1, 1'b0);
        @(posedge pclk);
        #1;
        m0_psel = 1'b1; m0_penable = 1'b0;
        m0_paddr = t[0].addr; m0_pwrite = t[0].wr; m0_pwdata = t[0].wdata;
        #1 slave_drive();
        n = 0;
        while (!out_penable && n < 10) begin tick(); n++; end
        chk("pre_reset_access", out_penable, 1);
        tick(); tick();
        @(posedge pclk);
        #1;
        preset = 1'b1; m0_psel = 1'b0; m0_penable = 1'b0;
        out_pready = 1'b1; out_prdata = 32'hFFFF_FFFF; out_pslverr = 1'b1;
        @(negedge pclk) chk_quiet("rst_in_access");
        @(posedge pclk);
        #1;
        preset = 1'b0; out_pready = 1'b0;
        @(negedge pclk) chk_quiet("rst_released");
        q.delete();
        lastg = 1;
        mon_en = 1'b1;
        rand_txn(1);
        run_round(1'b0, 1'b1, 1'b0);
        rand_txn(0); rand_txn(1);
        run_round(1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge pclk);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, need finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
